// File: rtl/d_latch_if.sv
// d_latch_if: data/enable inputs and latch outputs of d_latch.
// The parity signal exists only when D_LATCH_PARITY_EN is defined.
`timescale 1ns/1ps
interface d_latch_if #(parameter int WIDTH = 1);
  logic [WIDTH-1:0] d;
  logic             en;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic             hold_upd;
`ifdef D_LATCH_PARITY_EN
  logic             parity;
  modport master (output d, en, input q, q_valid, hold_upd, parity);
  modport slave  (input d, en, output q, q_valid, hold_upd, parity);
`else
  modport master (output d, en, input q, q_valid, hold_upd);
  modport slave  (input d, en, output q, q_valid, hold_upd);
`endif
endinterface

// File: rtl/d_latch.sv
// d_latch: clocked transparent/hold latch model with capture flag and hold-change pulse.
// Optional parity output is enabled by defining D_LATCH_PARITY_EN.
`timescale 1ns/1ps
module d_latch #(
  parameter int WIDTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  d_latch_if.slave     bus
);
  logic [WIDTH-1:0] hold;
  logic             valid;
  logic             upd;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hold  <= '0;
      valid <= 1'b0;
      upd   <= 1'b0;
    end else begin
      upd <= bus.en && (bus.d != hold);
      if (bus.en) begin
        hold  <= bus.d;
        valid <= 1'b1;
      end
    end
  // Output path is combinational so transparency has zero latency and reset wins at once.
  assign bus.q        = !rst_n ? '0 : bus.en ? bus.d : hold;
  assign bus.q_valid  = valid;
  assign bus.hold_upd = upd;
`ifdef D_LATCH_PARITY_EN
  assign bus.parity   = ^bus.q;
`endif
endmodule

// File: tb/tb_d_latch.sv
// tb_d_latch: directed-vector self-checking bench for d_latch (WIDTH=8).
`timescale 1ns/1ps
module tb_d_latch;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  d_latch_if #(.WIDTH(W)) bus ();
  d_latch #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic at(input int t);
    #(t - $time);
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    rst_n = 1'b0;
    bus.d = 8'hFF;
    bus.en = 1'b1;
    at(3);
    chk("rst_q", bus.q, 0);
    chk("rst_valid", bus.q_valid, 0);
    chk("rst_upd", bus.hold_upd, 0);
    at(19);
    chk("rst_q_late", bus.q, 0);
    chk("rst_valid_late", bus.q_valid, 0);
    at(22);
    rst_n = 1'b1;
    bus.d = 8'h00;
    bus.en = 1'b0;
    at(99);
    chk("idle_q", bus.q, 0);
    chk("idle_valid", bus.q_valid, 0);
    chk("idle_upd", bus.hold_upd, 0);
    at(100);
    bus.en = 1'b1;
    at(104);
    chk("tr_q0", bus.q, 8'h00);
    at(110);
    bus.d = 8'h01;
    at(111);
    chk("tr_q1", bus.q, 8'h01);
    at(116);
    chk("tr_valid", bus.q_valid, 1);
    chk("tr_upd", bus.hold_upd, 1);
    at(120);
    bus.en = 1'b0;
    at(121);
    chk("hold_q_en0", bus.q, 8'h01);
    at(126);
    chk("hold_upd_clr", bus.hold_upd, 0);
    at(130);
    bus.d = 8'h00;
    at(136);
    chk("hold_q_d0", bus.q, 8'h01);
    at(140);
    bus.en = 1'b1;
    at(156);
    chk("same_no_upd", bus.hold_upd, 0);
    at(160);
    bus.d = 8'hA5;
    at(166);
    chk("a5_upd", bus.hold_upd, 1);
    chk("a5_q", bus.q, 8'hA5);
    at(176);
    chk("a5_no_2nd", bus.hold_upd, 0);
    at(186);
    chk("a5_no_3rd", bus.hold_upd, 0);
    at(190);
    bus.d = 8'h3C;
    at(200);
    bus.en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      at(210 + 10 * i);
      bus.d = i[0] ? 8'h00 : 8'hFF;
      at(214 + 10 * i);
      chk("imm_q", bus.q, 8'h3C);
      chk("imm_upd", bus.hold_upd, 0);
    end
    at(310);
    bus.en = 1'b1;
    bus.d = 8'h5A;
    at(318);
    rst_n = 1'b0;
    at(319);
    chk("mrst_q", bus.q, 0);
    chk("mrst_valid", bus.q_valid, 0);
    chk("mrst_upd", bus.hold_upd, 0);
    at(322);
    rst_n = 1'b1;
    at(323);
    chk("mrst_rel_q", bus.q, 8'h5A);
    chk("mrst_rel_valid", bus.q_valid, 0);
    at(326);
    chk("mrst_recap_valid", bus.q_valid, 1);
    at(340);
    bus.d = 8'h11;
    at(350);
    bus.en = 1'b0;
    bus.d = 8'h22;
    at(354);
    chk("tog_q11", bus.q, 8'h11);
    at(360);
    bus.en = 1'b1;
    bus.d = 8'h33;
    at(370);
    bus.en = 1'b0;
    bus.d = 8'h44;
    at(374);
    chk("tog_q33", bus.q, 8'h33);
    at(380);
    bus.en = 1'b1;
    bus.d = 8'h77;
    at(381);
    chk("short_tr_q", bus.q, 8'h77);
    at(382);
    bus.en = 1'b0;
    at(383);
    chk("short_en_q", bus.q, 8'h33);
    at(396);
    chk("short_en_valid", bus.q_valid, 1);
`ifdef D_LATCH_PARITY_EN
    at(400);
    bus.en = 1'b1;
    bus.d = 8'h07;
    at(401);
    chk("par_07", bus.parity, 1);
    bus.d = 8'h03;
    at(402);
    chk("par_03", bus.parity, 0);
    rst_n = 1'b0;
    at(403);
    chk("par_rst", bus.parity, 0);
    rst_n = 1'b1;
`endif
    at(420);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/d_latch.md
D_LATCH -- requirements
Module: d_latch

Interface
REQ-001 Parameter: WIDTH, 1, data width in bits; legal range 1..64.
REQ-002 Port: clk input 1, single clock; all state updates on its rising edge.
REQ-003 Port: rst_n input 1, reset; asynchronous, active-low.
REQ-004 Port: d input WIDTH, data to pass through or hold.
REQ-005 Port: en input 1, latch enable; 1 = transparent, 0 = hold.
REQ-006 Port: q output WIDTH, latch output.
REQ-007 Port: q_valid output 1, high once a value has been captured since reset.
REQ-008 Port: hold_upd output 1, one-cycle pulse when the hold register changes value.
REQ-009 Port: parity output 1, XOR-reduction of q; present only when D_LATCH_PARITY_EN is defined.

Function
REQ-010 The block SHALL keep a WIDTH-bit hold register (hold) and a 1-bit capture flag (q_valid).
REQ-011 While en=1 and rst_n=1, q SHALL equal d combinationally, with zero-cycle latency.
REQ-012 While en=0 and rst_n=1, q SHALL equal hold and ignore d.
REQ-013 On each rising clk edge with en=1, hold SHALL load d and q_valid SHALL set to 1.
REQ-014 On each rising clk edge with en=0, hold and q_valid SHALL keep their values.
REQ-015 If en falls before any clk edge has sampled en=1, q SHALL show the previous hold value.
  - Stimulus MUST keep en high across at least one rising clk edge.
REQ-016 hold_upd SHALL be registered and go high for exactly one cycle after an edge where hold loaded a value different from its previous value.
  - Loading an identical value SHALL NOT pulse hold_upd.
REQ-017 A glitch on d while en=0 SHALL never reach q.
REQ-018 en toggling every cycle SHALL be legal; each en=1 edge captures, each en=0 edge holds.
REQ-019 There are no X-propagation exceptions: the behaviour above SHALL hold for every WIDTH bit independently and identically.

Reset
REQ-020 While rst_n=0, hold SHALL be 0, q_valid 0 and hold_upd 0 immediately, without waiting for a clk edge.
REQ-021 While rst_n=0, q SHALL be forced to 0 regardless of en or d.
REQ-022 After reset deasserts, behaviour SHALL resume at the next rising clk edge, with no spurious hold_upd pulse.
REQ-023 Reset asserted while en=1 SHALL override transparency; q returns to following d once rst_n=1.

Configuration
REQ-024 Macro D_LATCH_PARITY_EN defined: the block SHALL provide the parity port, combinationally equal to XOR of all bits of q; during reset parity SHALL be 0.
REQ-025 Macro D_LATCH_PARITY_EN undefined: the parity port and its logic SHALL be absent; all other behaviour SHALL be unchanged.

Verification
REQ-026 Reset hold: WIDTH=1, clk 10 ns, rst_n=0, d=1, en=1 -> q=0, q_valid=0, hold_upd=0 throughout reset.
REQ-027 Transparent then hold:
  - Stimulus: d=0, en=0 until 100 ns; en=1 at 100 ns; d=1 at 110 ns; en=0 at 120 ns; d=0 at 130 ns.
  - Required: q=0 at 105 ns, q=1 at 111 ns, q stays 1 at 135 ns, q_valid=1 after the 115 ns edge.
REQ-028 Update pulse: WIDTH=8, en=1, d=0x00 then 0xA5 for one cycle -> hold_upd high for exactly one cycle; d held at 0xA5 for a further cycle -> no second pulse.
REQ-029 Hold immunity: en=0 with hold=0x3C, d toggled 0xFF/0x00 every cycle for 10 cycles -> q=0x3C constant, hold_upd=0.
REQ-030 Mid-operation reset: en=1, d=0x5A, rst_n pulsed low between edges -> q=0 and q_valid=0 immediately; after release q=0x5A.
REQ-031 Parity build (D_LATCH_PARITY_EN defined): q=0x07 -> parity=1; q=0x03 -> parity=0.
